// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: state encoding, default parameters and small helpers shared by the sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_seq_pkg;

   localparam int         PC_W_DEF     = 8;
   localparam int         CNT_W_DEF    = 16;
   localparam int         MEM_WAIT_DEF = 1;
   localparam int         OP_W         = 4;
   localparam logic [3:0] HALT_OP_DEF  = 4'hF;

   // Main sequencer states; 3 bits covers all eight.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_FETCH  = 3'd2,
      ST_DECODE = 3'd3,
      ST_EXEC   = 3'd4,
      ST_MEM    = 3'd5,
      ST_WB     = 3'd6,
      ST_HALT   = 3'd7
   } state_t;

   // IDLE and HALT are the only resting states; everything else is working.
   function automatic logic is_busy_state(input state_t s);
      return (s != ST_IDLE) && (s != ST_HALT);
   endfunction

   // Program-load commands are honoured only while resting or already loading.
   function automatic logic accepts_load_cmd(input state_t s);
      return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_HALT);
   endfunction

endpackage

// File: rtl/seq_load_ctrl.sv
// seq_load_ctrl: program-load handshake, instruction-memory write address and overflow flag.
// Latency: byte written in the cycle it is accepted; address and error update on the next edge.
// Backpressure: ready comes from the sequencer (high for all of LOAD); no internal stall.
module seq_load_ctrl
   import cpu_seq_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr_i,
   input  logic            load_ready_i,
   input  logic            load_valid_i,
   input  logic            load_last_i,
   output logic            ins_write_o,
   output logic [PC_W-1:0] ins_addr_o,
   output logic            load_err_o,
   output logic            done_o
);

   logic [PC_W-1:0] addr_q;
   logic [PC_W-1:0] addr_d;
   logic            err_q;
   logic            err_d;
   logic            accept;
   logic            at_top;

   assign accept = load_valid_i & load_ready_i;
   assign at_top = &addr_q;

   // A byte at the top address without load_last is an overflow: the load ends there.
   assign done_o      = accept & (load_last_i | at_top);
   assign ins_write_o = accept;
   assign ins_addr_o  = addr_q;
   assign load_err_o  = err_q;

   // Next address / sticky error; a load command restarts both even if a byte lands this cycle.
   always_comb begin
      addr_d = addr_q;
      err_d  = err_q;
      if (clr_i) begin
         addr_d = '0;
         err_d  = 1'b0;
      end else if (accept) begin
         addr_d = addr_q + PC_W'(1);
         if (at_top && !load_last_i) begin
            err_d = 1'b1;
         end
      end
   end

   // Address counter and error flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         err_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 8-bit CPU (program load, then FETCH..WB per instruction).
// Latency: 4 cycles per non-memory instruction, 4+MEM_WAIT with a data-memory access.
// Backpressure: load_ready high for all of LOAD; start/load_start ignored while an instruction is in flight.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [OP_W-1:0] HALT_OP  = HALT_OP_DEF,
   parameter int              MEM_WAIT = MEM_WAIT_DEF,
   parameter int              CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_start,
   input  logic             load_valid,
   input  logic [7:0]       load_data,
   input  logic             load_last,
   output logic             load_ready,
   input  logic             start,
   input  logic             step_mode,
   input  logic [OP_W-1:0]  opcode,
   input  logic             cu_mem_read,
   input  logic             cu_mem_write,
   input  logic             cu_reg_write,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  ins_addr,
   output logic             ins_write,
   output logic             ins_read,
   output logic             ir_load,
   output logic             alu_en,
   output logic             mem_read_en,
   output logic             mem_write_en,
   output logic             reg_write_en,
   output logic             busy,
   output logic             halted,
   output logic             load_err,
   output logic [CNT_W-1:0] retired
);

   localparam int              WAIT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT - 1);

   state_t           state_q;
   state_t           state_d;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_d;
   logic [CNT_W-1:0] retired_q;
   logic [CNT_W-1:0] retired_d;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;

   logic load_ready_q;
   logic ins_read_q;
   logic ir_load_q;
   logic alu_en_q;
   logic mem_read_en_q;
   logic mem_write_en_q;
   logic reg_write_en_q;
   logic busy_q;
   logic halted_q;

   logic load_clr;
   logic load_done;
   logic mem_access;

   // load_data goes straight to instruction memory; the sequencer only qualifies it.
   logic unused_load_data;
   assign unused_load_data = ^load_data;

   assign load_clr   = load_start & accepts_load_cmd(state_q);
   assign mem_access = cu_mem_read | cu_mem_write;

   seq_load_ctrl #(
      .PC_W (PC_W)
   ) u_load (
      .clk          (clk),
      .reset        (reset),
      .clr_i        (load_clr),
      .load_ready_i (load_ready_q),
      .load_valid_i (load_valid),
      .load_last_i  (load_last),
      .ins_write_o  (ins_write),
      .ins_addr_o   (ins_addr),
      .load_err_o   (load_err),
      .done_o       (load_done)
   );

   // Next state, PC, retired count and MEM wait counter.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      wait_d    = wait_q;
      unique case (state_q)
         ST_IDLE: begin
            // load_start outranks start when both arrive together.
            if (load_start) begin
               state_d   = ST_LOAD;
               pc_d      = '0;
               retired_d = '0;
            end else if (start) begin
               state_d = ST_FETCH;
            end
         end
         ST_LOAD: begin
            // A fresh load_start keeps us here; the load controller rewinds to address 0.
            if (!load_start && load_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = (opcode == HALT_OP) ? ST_HALT : ST_EXEC;
         ST_EXEC: begin
            if (mem_access) begin
               state_d = ST_MEM;
               wait_d  = '0;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (wait_q == WAIT_LAST) begin
               state_d = ST_WB;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_WB: begin
            pc_d = pc_q + PC_W'(1);
            if (retired_q != '1) begin
               retired_d = retired_q + CNT_W'(1);
            end
            state_d = step_mode ? ST_IDLE : ST_FETCH;
         end
         ST_HALT: begin
            // Only a new program load (or reset) leaves HALT; pc keeps the HALT address.
            if (load_start) begin
               state_d   = ST_LOAD;
               pc_d      = '0;
               retired_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state plus strobes registered from the next state, so each strobe is a clean decode of the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         pc_q           <= '0;
         retired_q      <= '0;
         wait_q         <= '0;
         load_ready_q   <= 1'b0;
         ins_read_q     <= 1'b0;
         ir_load_q      <= 1'b0;
         alu_en_q       <= 1'b0;
         mem_read_en_q  <= 1'b0;
         mem_write_en_q <= 1'b0;
         reg_write_en_q <= 1'b0;
         busy_q         <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         retired_q      <= retired_d;
         wait_q         <= wait_d;
         load_ready_q   <= (state_d == ST_LOAD);
         ins_read_q     <= (state_d == ST_FETCH);
         ir_load_q      <= (state_d == ST_DECODE);
         alu_en_q       <= (state_d == ST_EXEC);
         // A write wins over a read when the CU asks for both.
         mem_write_en_q <= (state_d == ST_MEM) & cu_mem_write;
         mem_read_en_q  <= (state_d == ST_MEM) & cu_mem_read & ~cu_mem_write;
         reg_write_en_q <= (state_d == ST_WB) & cu_reg_write;
         busy_q         <= is_busy_state(state_d);
         halted_q       <= (state_d == ST_HALT);
      end
   end

   assign load_ready   = load_ready_q;
   assign pc           = pc_q;
   assign retired      = retired_q;
   assign ins_read     = ins_read_q;
   assign ir_load      = ir_load_q;
   assign alu_en       = alu_en_q;
   assign mem_read_en  = mem_read_en_q;
   assign mem_write_en = mem_write_en_q;
   assign reg_write_en = reg_write_en_q;
   assign busy         = busy_q;
   assign halted       = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer with a per-instruction strobe-sequence model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_sequencer;

   localparam int MW = 3;

   logic        clk;
   logic        reset;
   logic        load_start;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_last;
   logic        load_ready;
   logic        start;
   logic        step_mode;
   logic [3:0]  opcode;
   logic        cu_mem_read;
   logic        cu_mem_write;
   logic        cu_reg_write;
   logic [7:0]  pc;
   logic [7:0]  ins_addr;
   logic        ins_write;
   logic        ins_read;
   logic        ir_load;
   logic        alu_en;
   logic        mem_read_en;
   logic        mem_write_en;
   logic        reg_write_en;
   logic        busy;
   logic        halted;
   logic        load_err;
   logic [15:0] retired;

   cpu_sequencer #(
      .PC_W     (8),
      .HALT_OP  (4'hF),
      .MEM_WAIT (MW),
      .CNT_W    (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_start   (load_start),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .start        (start),
      .step_mode    (step_mode),
      .opcode       (opcode),
      .cu_mem_read  (cu_mem_read),
      .cu_mem_write (cu_mem_write),
      .cu_reg_write (cu_reg_write),
      .pc           (pc),
      .ins_addr     (ins_addr),
      .ins_write    (ins_write),
      .ins_read     (ins_read),
      .ir_load      (ir_load),
      .alu_en       (alu_en),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .reg_write_en (reg_write_en),
      .busy         (busy),
      .halted       (halted),
      .load_err     (load_err),
      .retired      (retired)
   );

   // Observed strobe vector: {ins_write, ins_read, ir_load, alu_en, mem_read_en, mem_write_en, reg_write_en, busy}
   localparam logic [7:0] S_BUSY = 8'h01;
   localparam logic [7:0] S_RW   = 8'h02;
   localparam logic [7:0] S_MW   = 8'h04;
   localparam logic [7:0] S_MR   = 8'h08;
   localparam logic [7:0] S_ALU  = 8'h10;
   localparam logic [7:0] S_IR   = 8'h20;
   localparam logic [7:0] S_IRD  = 8'h40;
   localparam logic [7:0] S_IW   = 8'h80;

   typedef struct packed {
      logic [7:0] str;
      logic [7:0] pc;
      logic [7:0] addr;
   } rec_t;

   typedef struct packed {
      logic [3:0] op;
      logic       rd;
      logic       wr;
      logic       rw;
   } ins_t;

   rec_t exp_q[$];
   ins_t drv_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   m_pc     = 0;
   int   m_ret    = 0;
   int   m_err    = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] s, input int a);
      rec_t r;
      r.str  = s | S_BUSY;
      r.pc   = 8'(m_pc);
      r.addr = 8'(a);
      exp_q.push_back(r);
   endtask

   // Reference model: one instruction is FETCH, DECODE, then (unless HALT) EXEC, MEM_WAIT memory cycles
   // when the CU asks for memory, and WB; the PC advances by one and the retired count by one.
   task automatic issue(input logic [3:0] op, input bit rd, input bit wr, input bit rw);
      ins_t i;
      i.op = op;
      i.rd = rd;
      i.wr = wr;
      i.rw = rw;
      drv_q.push_back(i);
      push(S_IRD, 0);
      push(S_IR, 0);
      if (op == 4'hF) return;
      push(S_ALU, 0);
      if (rd || wr) begin
         for (int k = 0; k < MW; k++) push(wr ? S_MW : S_MR, 0);
      end
      if (rw) push(S_RW, 0);
      m_pc = (m_pc + 1) % 256;
      if (m_ret < 65535) m_ret++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_quiet(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk(name, busy, 0);
   endtask

   task automatic do_load(input int n, input bit with_last, input bit gaps, input bit with_start);
      load_start = 1'b1;
      start      = with_start;
      tick();
      load_start = 1'b0;
      start      = 1'b0;
      m_pc  = 0;
      m_ret = 0;
      m_err = 0;
      chk("load_ready_entry", load_ready, 1);
      for (int k = 0; k < n; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         push(S_IW, k);
         load_valid = 1'b1;
         load_data  = 8'($urandom);
         load_last  = with_last && (k == n - 1);
         tick();
         load_valid = 1'b0;
         load_last  = 1'b0;
      end
      if (!with_last) m_err = 1;
      chk("load_exit_idle", busy, 0);
      chk("load_ready_exit", load_ready, 0);
      chk("load_err", load_err, m_err);
      chk("ins_addr_after_load", ins_addr, n % 256);
      chk("pc_after_load", pc, 0);
      chk("retired_after_load", retired, 0);
   endtask

   // Monitor: every cycle with a strobe must match the next expected event.
   initial begin
      rec_t       e;
      logic [7:0] obs;
      forever begin
         @(negedge clk);
         if (!reset) begin
            obs = {ins_write, ins_read, ir_load, alu_en, mem_read_en, mem_write_en, reg_write_en, busy};
            if ((obs & 8'hFE) != 8'h00) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_strobe got=%h pc=%0d addr=%0d", obs, pc, ins_addr);
               end else begin
                  e = exp_q.pop_front();
                  if (obs != e.str || pc != e.pc || (obs[7] && ins_addr != e.addr)) begin
                     failures++;
                     $display("FAIL seq_event got str=%h pc=%0d addr=%0d exp str=%h pc=%0d addr=%0d",
                              obs, pc, ins_addr, e.str, e.pc, e.addr);
                  end
               end
            end
         end
      end
   end

   // Control-unit stand-in: present the next instruction's decode once it is fetched.
   initial begin
      ins_t cur;
      opcode       = 4'h0;
      cu_mem_read  = 1'b0;
      cu_mem_write = 1'b0;
      cu_reg_write = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && ins_read && drv_q.size() > 0) begin
            cur          = drv_q.pop_front();
            opcode       = cur.op;
            cu_mem_read  = cur.rd;
            cu_mem_write = cur.wr;
            cu_reg_write = cur.rw;
         end
      end
   end

   initial begin
      #3000000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset      = 1'b1;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      start      = 1'b0;
      step_mode  = 1'b0;
      repeat (3) tick();
      chk("rst_pc", pc, 0);
      chk("rst_ins_addr", ins_addr, 0);
      chk("rst_retired", retired, 0);
      chk("rst_load_err", load_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_strobes", {ins_write, ins_read, ir_load, alu_en, mem_read_en, mem_write_en, reg_write_en}, 0);
      reset = 1'b0;
      tick();

      // Three-byte program load with idle gaps.
      do_load(3, 1'b1, 1'b1, 1'b0);

      // ALU op then HALT.
      issue(4'h1, 1'b0, 1'b0, 1'b1);
      issue(4'hF, 1'b0, 1'b0, 1'b0);
      pulse_start();
      wait_quiet(60, "alu_halt_done");
      chk("alu_halt_halted", halted, 1);
      chk("alu_halt_pc", pc, m_pc);
      chk("alu_halt_retired", retired, m_ret);

      // start is ignored in HALT.
      pulse_start();
      repeat (4) tick();
      chk("halt_hold", halted, 1);
      chk("halt_not_busy", busy, 0);
      chk("halt_pc_hold", pc, m_pc);

      // Store with both memory bits set, leaving HALT through a new load.
      do_load(2, 1'b1, 1'b0, 1'b0);
      issue(4'h3, 1'b1, 1'b1, 1'b0);
      issue(4'hF, 1'b0, 1'b0, 1'b0);
      pulse_start();
      wait_quiet(60, "store_done");
      chk("store_halted", halted, 1);
      chk("store_pc", pc, m_pc);
      chk("store_retired", retired, m_ret);

      // Single-step: one instruction per start, IDLE in between.
      do_load(4, 1'b1, 1'b1, 1'b0);
      step_mode = 1'b1;
      issue(4'h2, 1'b0, 1'b0, 1'b1);
      pulse_start();
      wait_quiet(30, "step1_done");
      chk("step1_pc", pc, m_pc);
      chk("step1_not_halted", halted, 0);
      issue(4'h5, 1'b1, 1'b0, 1'b1);
      pulse_start();
      wait_quiet(30, "step2_done");
      chk("step2_pc", pc, m_pc);
      chk("step2_retired", retired, m_ret);
      step_mode = 1'b0;

      // Long random program; the PC passes 255 -> 0 on the way.
      for (int k = 0; k < 300; k++) begin
         issue(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      issue(4'hF, 1'b0, 1'b0, 1'b0);
      pulse_start();
      wait_quiet(5000, "random_done");
      chk("random_halted", halted, 1);
      chk("random_pc", pc, m_pc);
      chk("random_retired", retired, m_ret);

      // 256 bytes without load_last: overflow.
      do_load(256, 1'b0, 1'b0, 1'b0);

      // start together with load_start in IDLE: LOAD wins.
      do_load(1, 1'b1, 1'b0, 1'b1);
      chk("ls_start_not_halted", halted, 0);
      chk("queue_drained", exp_q.size(), 0);

      // Reset in the middle of a memory access.
      issue(4'h6, 1'b1, 1'b0, 1'b1);
      issue(4'hF, 1'b0, 1'b0, 1'b0);
      pulse_start();
      for (int n = 0; n < 20 && !mem_read_en; n++) tick();
      chk("mem_reached", mem_read_en, 1);
      reset = 1'b1;
      #1;
      chk("mrst_strobes", {ins_write, ins_read, ir_load, alu_en, mem_read_en, mem_write_en, reg_write_en}, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_halted", halted, 0);
      chk("mrst_ins_addr", ins_addr, 0);
      chk("mrst_pc", pc, 0);
      chk("mrst_retired", retired, 0);
      chk("mrst_load_ready", load_ready, 0);
      exp_q.delete();
      drv_q.delete();
      m_pc  = 0;
      m_ret = 0;
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
